lfsr_rng_gen: RTL and testbench
===============================

# lfsr_rng_gen

Parametrised pseudo-random source for the mole-selection logic. A Fibonacci LFSR of configurable width and tap mask produces draws on request. Each draw is mapped into an exact range [OFFSET, OFFSET+RANGE-1] by bounded rejection sampling, so every LED index is unbiased. The block also supports runtime reseeding and an optional free-run mode that advances the LFSR between requests, so player timing adds entropy.

## Interface
- WIDTH, 18: LFSR length in bits (≥ 3).
- TAPS, 18'h20400: feedback mask; bit i set means lfsr[i] is XORed into feedback (default is x^18+x^11+1, maximal length).
- SEED, 18'd209347: reset/fallback state; must be non-zero and fit in WIDTH.
- RANGE, 18: number of distinct outputs (≥ 2).
- OFFSET, 0: added to every accepted draw.
- OUT_W, 5: output width; OFFSET+RANGE-1 must be < 2^OUT_W.
- MAX_TRIES, 8: rejection attempts per draw (≥ 1).
- FREE_RUN, 1: 1 means the LFSR advances every idle cycle; 0 means it advances only while drawing.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  WIDTH  new seed; 0 is replaced by SEED.
- req  in  1  draw request.
- busy  out  1  high while in DRAW.
- valid  out  1  one-cycle pulse; value updated this cycle.
- value  out  OUT_W  last accepted draw, held until the next accept.
- lfsr_state  out  WIDTH  current LFSR register (debug).

## Operation
- K = ceil(log2(RANGE)). The candidate is lfsr[K-1:0], taken from the pre-step register.
- Step: fb = ^(lfsr & TAPS); lfsr <= {lfsr[WIDTH-2:0], fb}.
- States:
  - IDLE: the LFSR steps only if FREE_RUN. When req is high, go to DRAW with tries <= 0.
  - DRAW: the LFSR steps every cycle.
    - If candidate < RANGE: value <= OFFSET + candidate, valid <= 1, go to IDLE.
    - Else if tries == MAX_TRIES-1: value <= OFFSET + (candidate - RANGE), valid <= 1, go to IDLE. This fallback always lies in range because candidate < 2^K < 2·RANGE.
    - Else tries <= tries+1 and stay in DRAW.
- Arithmetic is unsigned at OUT_W bits. tries is a counter of width ceil(log2(MAX_TRIES+1)).
- Priority: reset > seed_load > FSM.
- seed_load in any state:
  - lfsr <= (seed_in==0 ? SEED : seed_in).
  - state <= IDLE and valid <= 0; an in-flight draw is aborted with no valid.
  - value is held.
- Lock-up guard: if the LFSR ever holds all zeros outside reset or seed_load, the next edge loads SEED instead of stepping.
- req is ignored while busy. req held high in IDLE starts back-to-back draws.
- Reset values: lfsr=SEED, state=IDLE, tries=0, busy=0, valid=0, value=OFFSET.

## Timing
- busy is registered; it is high the cycle after the req edge, through the accepting edge.
- Latency: with req sampled at edge n, the earliest valid is high after edge n+1. The worst case is after edge n+MAX_TRIES.
- valid is high for exactly one cycle per completed draw. busy falls on the same edge valid rises.
- Reset or seed_load asserted mid-draw: the next cycle shows busy=0 and valid=0.
- A req on the cycle valid is high is accepted, giving a new DRAW on the next edge.

## Test plan
All scenarios use WIDTH=4, TAPS=4'b1100, SEED=1, RANGE=5, OFFSET=1, OUT_W=3, FREE_RUN=0 unless stated.
- Reset: hold reset=0 for 2 cycles -> lfsr_state=4'h1, value=1, valid=0, busy=0. Then apply 15 idle cycles with FREE_RUN=1 -> sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, back to 1 (period 15).
- Accepted draws: 4 single-cycle reqs, each waiting for valid -> values 2,3,5,2, each valid 2 clocks after req.
- Rejection: continue with 2 more reqs -> 5th gives value 4. The 6th rejects candidates 6 and 5, then accepts 2 -> value 3, valid 4 clocks after req.
- Fallback: rerun the rejection case with MAX_TRIES=2 -> the 6th draw gives value 1 (candidate 5-5=0, +1) after 2 DRAW cycles.
- Seed load: seed_load=1 with seed_in=0 during DRAW -> lfsr_state=SEED, busy=0, no valid, value unchanged. Then seed_in=4'h6 followed by req -> rejection path starts at 6.
- Lock-up: force lfsr to 0 via hierarchical deposit -> next edge lfsr_state=SEED. Assert that value never leaves [1,5] over 10k random reqs with default-width parameters.

Source files
------------

// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen
//   Pseudo-random source for the mole-selection logic. A Fibonacci LFSR
//   supplies candidates; each draw is mapped into [OFFSET, OFFSET+RANGE-1]
//   by bounded rejection sampling, with a folded fallback after MAX_TRIES
//   attempts so a draw always completes. The LFSR can be reseeded at
//   runtime and, in free-run mode, keeps advancing while idle so that
//   player timing adds entropy.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   reset       : synchronous, active-low reset
//   seed_load   : load seed_in into the LFSR (0 is replaced by SEED),
//                 aborting any draw in flight
//   seed_in     : new seed value
//   req         : draw request, ignored while busy
//   busy        : high while a draw is in progress
//   valid       : one-cycle pulse when value has been updated
//   value       : last accepted draw, held until the next accept
//   lfsr_state  : current LFSR register (debug visibility)
module lfsr_rng_gen #(
  parameter int unsigned       WIDTH     = 18,
  parameter logic [WIDTH-1:0]  TAPS      = 18'h20400,
  parameter logic [WIDTH-1:0]  SEED      = 18'd209347,
  parameter int unsigned       RANGE     = 18,
  parameter int unsigned       OFFSET    = 0,
  parameter int unsigned       OUT_W     = 5,
  parameter int unsigned       MAX_TRIES = 8,
  parameter bit                FREE_RUN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] lfsr_state
);

  // K is the number of LFSR bits needed to cover RANGE; TW sizes the
  // attempt counter so it can hold MAX_TRIES.
  localparam int unsigned K  = $clog2(RANGE);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  localparam logic [OUT_W-1:0] RANGE_V  = OUT_W'(RANGE);
  localparam logic [OUT_W-1:0] OFFSET_V = OUT_W'(OFFSET);
  localparam logic [TW-1:0]    LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [TW-1:0]      tries_q, tries_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               feedback;
  logic [WIDTH-1:0]   lfsr_step;
  logic [OUT_W-1:0]   candidate;
  logic               advance;

  // Fibonacci step and the candidate taken from the pre-step register.
  // The candidate is zero-extended to OUT_W so that all range arithmetic
  // happens unsigned at the output width.
  always_comb begin
    feedback  = ^(lfsr_q & TAPS);
    lfsr_step = {lfsr_q[WIDTH-2:0], feedback};
    candidate = '0;
    candidate[K-1:0] = lfsr_q[K-1:0];
  end

  // Next-state logic. The FSM result is computed first; the lock-up guard
  // then overrides the LFSR, and seed_load overrides everything except
  // value, which is deliberately held across a reseed.
  // The fallback (candidate - RANGE) is always in range because the
  // candidate is below 2^K, which is less than 2*RANGE.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    tries_d = tries_q;
    value_d = value_q;
    valid_d = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        advance = FREE_RUN;
        if (req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (candidate < RANGE_V) begin
          value_d = OFFSET_V + candidate;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (tries_q == LAST_TRY) begin
          value_d = OFFSET_V + (candidate - RANGE_V);
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      lfsr_d = lfsr_step;
    end

    if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end

    if (seed_load) begin
      lfsr_d  = (seed_in == '0) ? SEED : seed_in;
      state_d = IDLE;
      tries_d = '0;
      valid_d = 1'b0;
      value_d = value_q;
    end

    busy_d = (state_d == DRAW);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      tries_q <= '0;
      value_q <= OFFSET_V;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign value      = value_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// tb_lfsr_rng_gen
//   Scoreboard bench for lfsr_rng_gen. Four instances share clock and
//   reset: dutA (small LFSR, MAX_TRIES=8, FREE_RUN=0), dutB (same but
//   MAX_TRIES=2, driven in lock-step with dutA), dutC (free-running, used
//   for the LFSR sequence) and dutD (default 18-bit LFSR, RANGE=5,
//   OFFSET=1) which draws back-to-back for range checking.
//   Stimulus pushes expected value and completion cycle into per-DUT
//   queues; monitors pop and compare whenever valid is seen.
module tb_lfsr_rng_gen;

  typedef struct {
    logic [2:0] val;
    int         due;
  } expT;

  logic        clk;
  logic        reset;
  logic        seedLoad;
  logic [3:0]  seedIn;
  logic        req;

  logic        busyA, validA, busyB, validB, busyC, validC, busyD, validD;
  logic [2:0]  valueA, valueB, valueC, valueD;
  logic [3:0]  lfsrA, lfsrB, lfsrC;
  logic [17:0] lfsrD;

  logic        reqC;
  logic        seedLoadOff;
  logic [3:0]  seedInC;
  logic        reqD;
  logic [17:0] seedInD;

  int          cycleCnt;
  int          assertCount;
  int          failCount;
  int          countD;

  expT         qA[$];
  expT         qB[$];

  logic [3:0]  freeSeq [15];

  lfsr_rng_gen #(
    .WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .RANGE(5), .OFFSET(1),
    .OUT_W(3), .MAX_TRIES(8), .FREE_RUN(1'b0)
  ) dutA (
    .clk(clk), .reset(reset), .seed_load(seedLoad), .seed_in(seedIn),
    .req(req), .busy(busyA), .valid(validA), .value(valueA),
    .lfsr_state(lfsrA)
  );

  lfsr_rng_gen #(
    .WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .RANGE(5), .OFFSET(1),
    .OUT_W(3), .MAX_TRIES(2), .FREE_RUN(1'b0)
  ) dutB (
    .clk(clk), .reset(reset), .seed_load(seedLoad), .seed_in(seedIn),
    .req(req), .busy(busyB), .valid(validB), .value(valueB),
    .lfsr_state(lfsrB)
  );

  lfsr_rng_gen #(
    .WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .RANGE(5), .OFFSET(1),
    .OUT_W(3), .MAX_TRIES(8), .FREE_RUN(1'b1)
  ) dutC (
    .clk(clk), .reset(reset), .seed_load(seedLoadOff), .seed_in(seedInC),
    .req(reqC), .busy(busyC), .valid(validC), .value(valueC),
    .lfsr_state(lfsrC)
  );

  lfsr_rng_gen #(
    .RANGE(5), .OFFSET(1), .OUT_W(3), .MAX_TRIES(8), .FREE_RUN(1'b1)
  ) dutD (
    .clk(clk), .reset(reset), .seed_load(seedLoadOff), .seed_in(seedInD),
    .req(reqD), .busy(busyD), .valid(validD), .value(valueD),
    .lfsr_state(lfsrD)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts rising edges so that completion cycles can be predicted.
  initial begin
    cycleCnt = 0;
    forever begin
      @(posedge clk);
      cycleCnt = cycleCnt + 1;
    end
  end

  // Safety net in case something stalls beyond every local bound.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one draw request to dutA/dutB, records expected results and
  // waits (bounded) until both monitors have consumed them.
  task automatic applyStimulus(input logic [2:0] expA, input int latA,
                               input logic [2:0] expB, input int latB);
    expT e;
    int  waited;
    e.val = expA;
    e.due = cycleCnt + latA;
    qA.push_back(e);
    e.val = expB;
    e.due = cycleCnt + latB;
    qB.push_back(e);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checkOutput("A busy after req", {31'd0, busyA}, 32'd1);
    checkOutput("B busy after req", {31'd0, busyB}, 32'd1);
    waited = 0;
    while ((qA.size() != 0 || qB.size() != 0) && waited < 20) begin
      @(negedge clk);
      #1;
      waited = waited + 1;
    end
    if (qA.size() != 0 || qB.size() != 0) begin
      checkOutput("draw completion timeout", 32'(qA.size() + qB.size()), 32'd0);
      qA.delete();
      qB.delete();
    end
  endtask

  // Monitor for dutA: every valid must match the oldest pending draw.
  always @(negedge clk) begin
    if (validA === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("A valid without pending draw", {31'd0, validA}, 32'd0);
      end else begin
        expT e;
        e = qA.pop_front();
        checkOutput("A value", {29'd0, valueA}, {29'd0, e.val});
        checkOutput("A latency", 32'(cycleCnt), 32'(e.due));
        checkOutput("A busy at valid", {31'd0, busyA}, 32'd0);
      end
    end
  end

  // Monitor for dutB, same scheme as dutA.
  always @(negedge clk) begin
    if (validB === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("B valid without pending draw", {31'd0, validB}, 32'd0);
      end else begin
        expT e;
        e = qB.pop_front();
        checkOutput("B value", {29'd0, valueB}, {29'd0, e.val});
        checkOutput("B latency", 32'(cycleCnt), 32'(e.due));
        checkOutput("B busy at valid", {31'd0, busyB}, 32'd0);
      end
    end
  end

  // Monitor for dutD: every accepted draw must lie in [1,5].
  always @(negedge clk) begin
    if (validD === 1'b1) begin
      checkOutput("D value in range",
                  {31'd0, (valueD >= 3'd1 && valueD <= 3'd5)}, 32'd1);
      countD = countD + 1;
    end
  end

  initial begin
    int waited;
    assertCount = 0;
    failCount   = 0;
    countD      = 0;
    reset       = 1'b0;
    seedLoad    = 1'b0;
    seedIn      = 4'h0;
    req         = 1'b0;
    reqC        = 1'b0;
    reqD        = 1'b0;
    seedLoadOff = 1'b0;
    seedInC     = 4'h0;
    seedInD     = 18'h0;
    freeSeq     = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                    4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    repeat (2) @(negedge clk);
    checkOutput("reset lfsr_state", {28'd0, lfsrA}, 32'h1);
    checkOutput("reset value",      {29'd0, valueA}, 32'd1);
    checkOutput("reset valid",      {31'd0, validA}, 32'd0);
    checkOutput("reset busy",       {31'd0, busyA}, 32'd0);
    checkOutput("reset C lfsr",     {28'd0, lfsrC}, 32'h1);
    reset = 1'b1;
    reqD  = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput($sformatf("free-run step %0d", i + 1),
                  {28'd0, lfsrC}, {28'd0, freeSeq[i]});
    end
    checkOutput("A holds lfsr when idle", {28'd0, lfsrA}, 32'h1);

    applyStimulus(3'd2, 2, 3'd2, 2);
    applyStimulus(3'd3, 2, 3'd3, 2);
    applyStimulus(3'd5, 2, 3'd5, 2);
    applyStimulus(3'd2, 2, 3'd2, 2);
    applyStimulus(3'd4, 2, 3'd4, 2);
    applyStimulus(3'd3, 4, 3'd1, 3);

    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checkOutput("A busy before abort", {31'd0, busyA}, 32'd1);
    seedLoad = 1'b1;
    seedIn   = 4'h0;
    @(negedge clk);
    seedLoad = 1'b0;
    checkOutput("abort A busy",  {31'd0, busyA}, 32'd0);
    checkOutput("abort A valid", {31'd0, validA}, 32'd0);
    checkOutput("abort A lfsr",  {28'd0, lfsrA}, 32'h1);
    checkOutput("abort A value", {29'd0, valueA}, 32'd3);
    checkOutput("abort B busy",  {31'd0, busyB}, 32'd0);
    checkOutput("abort B valid", {31'd0, validB}, 32'd0);
    checkOutput("abort B lfsr",  {28'd0, lfsrB}, 32'h1);
    checkOutput("abort B value", {29'd0, valueB}, 32'd1);

    seedLoad = 1'b1;
    seedIn   = 4'h6;
    @(negedge clk);
    seedLoad = 1'b0;
    checkOutput("seed load A lfsr", {28'd0, lfsrA}, 32'h6);
    checkOutput("seed load B lfsr", {28'd0, lfsrB}, 32'h6);
    applyStimulus(3'd3, 4, 3'd1, 3);

    @(negedge clk);
    force dutA.lfsr_q = 4'h0;
    #1;
    release dutA.lfsr_q;
    @(negedge clk);
    checkOutput("lock-up recovery", {28'd0, lfsrA}, 32'h1);

    waited = 0;
    while (countD < 10000 && waited < 60000) begin
      @(negedge clk);
      waited = waited + 1;
    end
    reqD = 1'b0;
    checkOutput("D draws completed", {31'd0, (countD >= 10000)}, 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
